// File: rtl/stage_mem_writer_if.sv
// Upstream record handshake, memory write port and stage status signals
// of the per-stage node memory writer, bundled for port connection.
interface stage_mem_writer_if #(
  parameter int NUM_NODES = 32,
  parameter int DEPTH     = 4,
  parameter int DATA_SIZE = 4
);
  // Upstream record offer
  logic [$clog2(NUM_NODES)-1:0] nodeIdx;
  logic [3*DATA_SIZE-1:0]       dataIn;
  logic                         sendValid;
  logic                         sendReady;
  // Memory write port
  logic                         we;
  logic [DEPTH-1:0]             address;
  logic [3*DATA_SIZE-1:0]       dataBusOut;
  logic                         memRdy;
  // Status and stage control
  logic                         wrDone;
  logic                         rangeErr;
  logic                         clearStage;
  logic                         stageFull;
  logic                         idle;

  modport master (
    output nodeIdx, dataIn, sendValid, memRdy, clearStage,
    input  sendReady, we, address, dataBusOut, wrDone, rangeErr, stageFull, idle
  );

  modport slave (
    input  nodeIdx, dataIn, sendValid, memRdy, clearStage,
    output sendReady, we, address, dataBusOut, wrDone, rangeErr, stageFull, idle
  );
endinterface

// File: rtl/stage_mem_writer.sv
// Write-side controller for the per-stage node memory: buffers incoming
// (nodeIdx, data) records, maps global indices to stage-local addresses,
// issues memory writes held until memRdy, and tracks stage completeness.
module stage_mem_writer #(
  parameter int NUM_NODES  = 32,
  parameter int DEPTH      = 4,
  parameter int DATA_SIZE  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  stage_mem_writer_if.slave  bus
);
  localparam int          REC_W  = 3 * DATA_SIZE;
  localparam int          PTR_W  = $clog2(FIFO_DEPTH);
  localparam int          CNT_W  = PTR_W + 1;
  localparam int unsigned NENT   = 1 << DEPTH;
  localparam int unsigned LO_IDX = 1 << DEPTH;
  localparam int unsigned HI_IDX = 2 << DEPTH;

  typedef enum logic {W_IDLE, W_ISSUE} state_t;

  state_t             state;
  logic [DEPTH-1:0]   fifo_addr [FIFO_DEPTH];
  logic [REC_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               ready_en;
  logic [NENT-1:0]    bitmap;
  logic [NENT-1:0]    bitmap_next;

  logic               we_p1;
  logic [DEPTH-1:0]   address_p1;
  logic [REC_W-1:0]   data_p1;
  logic               wr_done_p1;
  logic               range_err_p1;
  logic               stage_full_p1;

  logic fifo_empty, fifo_full, accept, in_range, push, pop, complete;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  // ready_en keeps sendReady low through reset and rises the cycle after.
  assign bus.sendReady = ready_en && !fifo_full;
  assign accept   = bus.sendValid && bus.sendReady;
  assign in_range = (32'(bus.nodeIdx) >= LO_IDX) && (32'(bus.nodeIdx) < HI_IDX);
  assign push     = accept && in_range;
  assign complete = (state == W_ISSUE) && bus.memRdy;
  // Head leaves the FIFO when loaded from idle or on a back-to-back completion.
  assign pop      = !fifo_empty && ((state == W_IDLE) || complete);

  // Clear takes effect before the completing write sets its bit.
  assign bitmap_next = (bus.clearStage ? '0 : bitmap)
                     | (complete ? (NENT'(1) << address_p1) : '0);

  assign bus.we         = we_p1;
  assign bus.address    = address_p1;
  assign bus.dataBusOut = data_p1;
  assign bus.wrDone     = wr_done_p1;
  assign bus.rangeErr   = range_err_p1;
  assign bus.stageFull  = stage_full_p1;
  assign bus.idle       = fifo_empty && (state == W_IDLE);

  // ---- stage p0: enqueue record; in-range indices subtract 1<<DEPTH by dropping the top bits
  // FIFO payload storage, written on accepted in-range records
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.nodeIdx[DEPTH-1:0];
      fifo_data[wr_ptr] <= bus.dataIn;
    end
  end

  // FIFO pointers, occupancy and post-reset ready enable
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---- stage p1: write issue FSM, completion pulses and stage bitmap
  // Write FSM with registered memory-port and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= W_IDLE;
      we_p1         <= 1'b0;
      address_p1    <= '0;
      data_p1       <= '0;
      wr_done_p1    <= 1'b0;
      range_err_p1  <= 1'b0;
      stage_full_p1 <= 1'b0;
      bitmap        <= '0;
    end else begin
      wr_done_p1    <= complete;
      range_err_p1  <= accept && !in_range;
      bitmap        <= bitmap_next;
      stage_full_p1 <= &bitmap_next;
      case (state)
        W_IDLE: begin
          if (!fifo_empty) begin
            address_p1 <= fifo_addr[rd_ptr];
            data_p1    <= fifo_data[rd_ptr];
            we_p1      <= 1'b1;
            state      <= W_ISSUE;
          end
        end
        W_ISSUE: begin
          if (bus.memRdy) begin
            if (!fifo_empty) begin
              address_p1 <= fifo_addr[rd_ptr];
              data_p1    <= fifo_data[rd_ptr];
            end else begin
              we_p1 <= 1'b0;
              state <= W_IDLE;
            end
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stage_mem_writer.sv
// Directed self-checking bench for stage_mem_writer (NUM_NODES=64 so that
// index 32 is representable for the out-of-range case).
module tb_stage_mem_writer;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  stage_mem_writer_if #(.NUM_NODES(64), .DEPTH(4), .DATA_SIZE(4)) bus ();

  stage_mem_writer #(.NUM_NODES(64), .DEPTH(4), .DATA_SIZE(4), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sendValid = 1'b0;
    bus.clearStage = 1'b0;
    bus.memRdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.nodeIdx = '0;
    bus.dataIn = '0;
    bus.sendValid = 1'b0;
    bus.memRdy = 1'b0;
    bus.clearStage = 1'b0;
    tick();
    tick();
    vectors++; if (bus.we !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b want 0", bus.we); end
    vectors++; if (bus.wrDone !== 1'b0) begin miscompares++; $display("FAIL rst_wrDone: got %b want 0", bus.wrDone); end
    vectors++; if (bus.rangeErr !== 1'b0) begin miscompares++; $display("FAIL rst_rangeErr: got %b want 0", bus.rangeErr); end
    vectors++; if (bus.stageFull !== 1'b0) begin miscompares++; $display("FAIL rst_stageFull: got %b want 0", bus.stageFull); end
    vectors++; if (bus.sendReady !== 1'b0) begin miscompares++; $display("FAIL rst_sendReady: got %b want 0", bus.sendReady); end
    vectors++; if (bus.address !== 4'h0) begin miscompares++; $display("FAIL rst_address: got %h want 0", bus.address); end
    vectors++; if (bus.dataBusOut !== 12'h000) begin miscompares++; $display("FAIL rst_data: got %h want 000", bus.dataBusOut); end
    vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL rst_idle: got %b want 1", bus.idle); end
    rst = 1'b0;
    tick();
    vectors++; if (bus.sendReady !== 1'b1) begin miscompares++; $display("FAIL post_rst_sendReady: got %b want 1", bus.sendReady); end
  endtask

  task automatic test_single_write();
    // c0: offer index 17
    bus.nodeIdx = 6'd17; bus.dataIn = 12'hABC; bus.sendValid = 1'b1; bus.memRdy = 1'b1;
    tick();
    // c1: record is in the FIFO, no write yet
    bus.sendValid = 1'b0;
    vectors++; if (bus.we !== 1'b0) begin miscompares++; $display("FAIL single_c1_we: got %b want 0", bus.we); end
    vectors++; if (bus.idle !== 1'b0) begin miscompares++; $display("FAIL single_c1_idle: got %b want 0", bus.idle); end
    tick();
    // c2: write presented
    vectors++; if (bus.we !== 1'b1) begin miscompares++; $display("FAIL single_c2_we: got %b want 1", bus.we); end
    vectors++; if (bus.address !== 4'd1) begin miscompares++; $display("FAIL single_c2_addr: got %0d want 1", bus.address); end
    vectors++; if (bus.dataBusOut !== 12'hABC) begin miscompares++; $display("FAIL single_c2_data: got %h want abc", bus.dataBusOut); end
    tick();
    // c3: completion pulse, back to idle
    vectors++; if (bus.wrDone !== 1'b1) begin miscompares++; $display("FAIL single_c3_wrDone: got %b want 1", bus.wrDone); end
    vectors++; if (bus.we !== 1'b0) begin miscompares++; $display("FAIL single_c3_we: got %b want 0", bus.we); end
    vectors++; if (bus.idle !== 1'b1) begin miscompares++; $display("FAIL single_c3_idle: got %b want 1", bus.idle); end
    tick();
    vectors++; if (bus.wrDone !== 1'b0) begin miscompares++; $display("FAIL single_c4_wrDone: got %b want 0", bus.wrDone); end
  endtask

  task automatic test_backpressure();
    bus.memRdy = 1'b0;
    bus.nodeIdx = 6'd16; bus.dataIn = 12'h111; bus.sendValid = 1'b1;
    tick();
    bus.nodeIdx = 6'd18; bus.dataIn = 12'h222;
    vectors++; if (bus.sendReady !== 1'b1) begin miscompares++; $display("FAIL bp_c1_ready: got %b want 1", bus.sendReady); end
    tick();
    bus.nodeIdx = 6'd20; bus.dataIn = 12'h333;
    vectors++; if (bus.sendReady !== 1'b1) begin miscompares++; $display("FAIL bp_c2_ready: got %b want 1", bus.sendReady); end
    vectors++; if (bus.we !== 1'b1) begin miscompares++; $display("FAIL bp_c2_we: got %b want 1", bus.we); end
    vectors++; if (bus.address !== 4'd0) begin miscompares++; $display("FAIL bp_c2_addr: got %0d want 0", bus.address); end
    tick();
    bus.sendValid = 1'b0;
    // c3..c6: first write held, FIFO full
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bus.sendReady !== 1'b0) begin miscompares++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, bus.sendReady); end
      vectors++; if (bus.we !== 1'b1 || bus.address !== 4'd0 || bus.dataBusOut !== 12'h111)
        begin miscompares++; $display("FAIL bp_hold[%0d]: got we=%b addr=%0d data=%h want 1/0/111", i, bus.we, bus.address, bus.dataBusOut); end
      vectors++; if (bus.wrDone !== 1'b0) begin miscompares++; $display("FAIL bp_hold_wrDone[%0d]: got %b want 0", i, bus.wrDone); end
      if (i < 3) tick();
    end
    bus.memRdy = 1'b1;
    tick();
    vectors++; if (bus.we !== 1'b1 || bus.address !== 4'd2 || bus.dataBusOut !== 12'h222 || bus.wrDone !== 1'b1)
      begin miscompares++; $display("FAIL bp_w2: got we=%b addr=%0d data=%h done=%b want 1/2/222/1", bus.we, bus.address, bus.dataBusOut, bus.wrDone); end
    tick();
    vectors++; if (bus.we !== 1'b1 || bus.address !== 4'd4 || bus.dataBusOut !== 12'h333 || bus.wrDone !== 1'b1)
      begin miscompares++; $display("FAIL bp_w3: got we=%b addr=%0d data=%h done=%b want 1/4/333/1", bus.we, bus.address, bus.dataBusOut, bus.wrDone); end
    tick();
    vectors++; if (bus.we !== 1'b0 || bus.wrDone !== 1'b1 || bus.idle !== 1'b1)
      begin miscompares++; $display("FAIL bp_end: got we=%b done=%b idle=%b want 0/1/1", bus.we, bus.wrDone, bus.idle); end
    tick();
    vectors++; if (bus.wrDone !== 1'b0) begin miscompares++; $display("FAIL bp_after_wrDone: got %b want 0", bus.wrDone); end
  endtask

  task automatic test_range_error();
    bus.memRdy = 1'b1;
    bus.nodeIdx = 6'd5; bus.dataIn = 12'h055; bus.sendValid = 1'b1;
    tick();
    vectors++; if (bus.rangeErr !== 1'b1) begin miscompares++; $display("FAIL range_lo_err: got %b want 1", bus.rangeErr); end
    vectors++; if (bus.we !== 1'b0 || bus.idle !== 1'b1) begin miscompares++; $display("FAIL range_lo_state: got we=%b idle=%b want 0/1", bus.we, bus.idle); end
    bus.nodeIdx = 6'd32; bus.dataIn = 12'h032;
    tick();
    bus.sendValid = 1'b0;
    vectors++; if (bus.rangeErr !== 1'b1) begin miscompares++; $display("FAIL range_hi_err: got %b want 1", bus.rangeErr); end
    vectors++; if (bus.we !== 1'b0 || bus.idle !== 1'b1) begin miscompares++; $display("FAIL range_hi_state: got we=%b idle=%b want 0/1", bus.we, bus.idle); end
    tick();
    vectors++; if (bus.rangeErr !== 1'b0) begin miscompares++; $display("FAIL range_end_err: got %b want 0", bus.rangeErr); end
    vectors++; if (bus.we !== 1'b0 || bus.idle !== 1'b1) begin miscompares++; $display("FAIL range_end_state: got we=%b idle=%b want 0/1", bus.we, bus.idle); end
  endtask

  task automatic test_fill();
    // 17 records: offset 3 repeats, offset 8 is the 16th distinct and comes last
    int offs [17] = '{5, 0, 12, 3, 9, 3, 15, 1, 7, 10, 2, 14, 6, 11, 4, 13, 8};
    int n_done = 0;
    do_reset();
    bus.memRdy = 1'b1;
    fork
      begin
        for (int k = 0; k < 17; k++) begin
          int wait_cnt;
          bus.nodeIdx = 6'(16 + offs[k]); bus.dataIn = 12'(offs[k] * 3); bus.sendValid = 1'b1;
          wait_cnt = 0;
          while (bus.sendReady !== 1'b1 && wait_cnt < 20) begin tick(); wait_cnt++; end
          if (wait_cnt >= 20) begin miscompares++; $display("FAIL fill_accept_timeout[%0d]: got sendReady=%b want 1", k, bus.sendReady); end
          tick();
        end
        bus.sendValid = 1'b0;
      end
      begin
        repeat (40) begin
          @(negedge clk);
          if (bus.wrDone === 1'b1) n_done++;
          vectors++; if (bus.stageFull !== (n_done >= 17))
            begin miscompares++; $display("FAIL fill_stageFull: got %b want %b after %0d completions", bus.stageFull, (n_done >= 17), n_done); end
        end
      end
    join
    vectors++; if (n_done != 17) begin miscompares++; $display("FAIL fill_count: got %0d want 17", n_done); end
  endtask

  task automatic test_clear_collision();
    bus.memRdy = 1'b1;
    bus.nodeIdx = 6'd23; bus.dataIn = 12'h777; bus.sendValid = 1'b1;
    tick();
    bus.sendValid = 1'b0;
    tick();
    vectors++; if (bus.we !== 1'b1 || bus.address !== 4'd7 || bus.stageFull !== 1'b1)
      begin miscompares++; $display("FAIL clr_pre: got we=%b addr=%0d full=%b want 1/7/1", bus.we, bus.address, bus.stageFull); end
    bus.clearStage = 1'b1;
    tick();
    bus.clearStage = 1'b0;
    vectors++; if (bus.stageFull !== 1'b0) begin miscompares++; $display("FAIL clr_stageFull: got %b want 0", bus.stageFull); end
    vectors++; if (dut.bitmap !== 16'h0080) begin miscompares++; $display("FAIL clr_bitmap: got %h want 0080", dut.bitmap); end
    vectors++; if (bus.wrDone !== 1'b1) begin miscompares++; $display("FAIL clr_wrDone: got %b want 1", bus.wrDone); end
  endtask

  task automatic test_mid_reset();
    bus.memRdy = 1'b0;
    bus.nodeIdx = 6'd16; bus.dataIn = 12'h0A0; bus.sendValid = 1'b1;
    tick();
    bus.nodeIdx = 6'd17; bus.dataIn = 12'h0A1;
    tick();
    bus.nodeIdx = 6'd18; bus.dataIn = 12'h0A2;
    tick();
    bus.sendValid = 1'b0;
    vectors++; if (bus.we !== 1'b1 || bus.sendReady !== 1'b0)
      begin miscompares++; $display("FAIL mrst_pre: got we=%b ready=%b want 1/0", bus.we, bus.sendReady); end
    rst = 1'b1;
    tick();
    vectors++; if (bus.we !== 1'b0 || bus.idle !== 1'b1)
      begin miscompares++; $display("FAIL mrst_during: got we=%b idle=%b want 0/1", bus.we, bus.idle); end
    rst = 1'b0;
    bus.memRdy = 1'b1;
    tick();
    vectors++; if (bus.sendReady !== 1'b1 || bus.we !== 1'b0 || bus.idle !== 1'b1)
      begin miscompares++; $display("FAIL mrst_after: got ready=%b we=%b idle=%b want 1/0/1", bus.sendReady, bus.we, bus.idle); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (bus.wrDone !== 1'b0 || bus.we !== 1'b0)
        begin miscompares++; $display("FAIL mrst_quiet[%0d]: got wrDone=%b we=%b want 0/0", i, bus.wrDone, bus.we); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_backpressure();
    test_range_error();
    test_fill();
    test_clear_collision();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
